// File: rtl/icm_pkg.sv
// Shared definitions for the ICM frame deserializer: FSM state encoding and the
// legacy LTC payload width.
package icm_pkg;

    localparam int ICM_LTC_W = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDY,
        ST_START_0,
        ST_START_1,
        ST_SHIFT,
        ST_STOP
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that wins over a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sync.sv
// Two-flop synchroniser that brings the asynchronous serial line into the clk domain.
module sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_d;
    logic [1:0] ff_q;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/icm_frame_des.sv
// Recovers fixed-length ICM serial frames into a parallel payload with a valid strobe,
// keeping saturating counters of good frames and of each error cause.
module icm_frame_des
    import icm_pkg::*;
#(
    parameter int DATA_W       = ICM_LTC_W,
    parameter int PARITY_EN    = 0,
    parameter int SHIFT_CNT    = 20,
    parameter int IDLE_CNT     = 2000,
    parameter int STOP_ERR_CNT = 100,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ser_in,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              armed,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_frame_cnt,
    output logic [CNT_W-1:0]  err_par_cnt,
    output logic [CNT_W-1:0]  err_to_cnt
);

    localparam int N       = DATA_W + 2 + PARITY_EN;
    localparam int TMR_MAX = (IDLE_CNT > STOP_ERR_CNT)
                             ? ((IDLE_CNT > SHIFT_CNT) ? IDLE_CNT : SHIFT_CNT)
                             : ((STOP_ERR_CNT > SHIFT_CNT) ? STOP_ERR_CNT : SHIFT_CNT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(N + 1);

    localparam logic [TMR_W-1:0] IDLE_LAST = TMR_W'(IDLE_CNT - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(STOP_ERR_CNT - 1);
    localparam logic [TMR_W-1:0] HALF      = TMR_W'(SHIFT_CNT / 2);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(SHIFT_CNT / 2 - 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(SHIFT_CNT - 1);
    localparam logic [BIT_W-1:0] N_LAST    = BIT_W'(N - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic              ser_s;
    state_e            state_d, state_q;
    logic [TMR_W-1:0]  tmr_d, tmr_q;
    logic [BIT_W-1:0]  bit_d, bit_q;
    logic [N-1:0]      shreg_d, shreg_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;
    logic              inc_frame, inc_ferr, inc_perr, inc_to;
    logic              framing_bad, parity_bad;

    sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ser_in),
        .q   (ser_s)
    );

    // Frame is shifted in MSB first: leading framing bit ends up at the top, trailing at bit 0.
    assign framing_bad = shreg_q[N-1] | shreg_q[0];
    assign parity_bad  = (PARITY_EN != 0) && (^shreg_q[N-2:1]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        inc_frame = 1'b0;
        inc_ferr  = 1'b0;
        inc_perr  = 1'b0;
        inc_to    = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            bit_d   = '0;
            shreg_d = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ser_s) begin
                        tmr_d = '0;
                    end else if (tmr_q == IDLE_LAST) begin
                        state_d = ST_RDY;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_RDY: begin
                    if (!ser_s) begin
                        state_d = ST_START_0;
                        tmr_d   = TMR_ONE;
                    end
                end
                ST_START_0: begin
                    if (ser_s) begin
                        state_d = ST_START_1;
                        tmr_d   = TMR_ONE;
                    end else if (tmr_q == TO_LAST) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                        inc_to  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_START_1: begin
                    if (!ser_s) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                        inc_to  = 1'b1;
                    end else if (tmr_q == HALF_LAST) begin
                        // Half a bit into the marker, so every later sample lands mid-bit.
                        state_d = ST_SHIFT;
                        tmr_d   = '0;
                        bit_d   = '0;
                        shreg_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (tmr_q == BIT_LAST) begin
                        tmr_d   = '0;
                        shreg_d = {shreg_q[N-2:0], ser_s};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == N_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (ser_s && (tmr_q >= HALF)) begin
                        state_d = ST_RDY;
                        tmr_d   = '0;
                        if (framing_bad) begin
                            inc_ferr = 1'b1;
                        end else if (parity_bad) begin
                            inc_perr = 1'b1;
                        end else begin
                            data_d    = shreg_q[N-2 -: DATA_W];
                            valid_d   = 1'b1;
                            inc_frame = 1'b1;
                        end
                    end else if (tmr_q == TO_LAST) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                        inc_to  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk (clk), .rst (rst), .inc (inc_frame), .clr (clr_cnt), .cnt (frame_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_frame_cnt (
        .clk (clk), .rst (rst), .inc (inc_ferr), .clr (clr_cnt), .cnt (err_frame_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_par_cnt (
        .clk (clk), .rst (rst), .inc (inc_perr), .clr (clr_cnt), .cnt (err_par_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_to_cnt (
        .clk (clk), .rst (rst), .inc (inc_to), .clr (clr_cnt), .cnt (err_to_cnt)
    );

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign armed     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icm_frame_des.sv
// Directed bench for icm_frame_des: three configurations (48-bit plain, 32-bit with
// parity, 2-bit counters) share one serial driver, routed to one DUT at a time.
module tb_icm_frame_des;

    localparam int SC = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ser_bit;
    int   sel;
    logic en_c, clr_a, clr_c;
    logic ser_a, ser_b, ser_c;

    assign ser_a = (sel == 0) ? ser_bit : 1'b1;
    assign ser_b = (sel == 1) ? ser_bit : 1'b1;
    assign ser_c = (sel == 2) ? ser_bit : 1'b1;

    logic [47:0] data_a;
    logic        valid_a, armed_a;
    logic [15:0] fcnt_a, ferr_a, perr_a, to_a;

    logic [31:0] data_b;
    logic        valid_b, armed_b;
    logic [15:0] fcnt_b, ferr_b, perr_b, to_b;

    logic [47:0] data_c;
    logic        valid_c, armed_c;
    logic [1:0]  fcnt_c, ferr_c, perr_c, to_c;

    icm_frame_des u_dut_a (
        .clk (clk), .rst (rst), .en (1'b1), .ser_in (ser_a), .clr_cnt (clr_a),
        .data_out (data_a), .valid_out (valid_a), .armed (armed_a),
        .frame_cnt (fcnt_a), .err_frame_cnt (ferr_a), .err_par_cnt (perr_a), .err_to_cnt (to_a)
    );

    icm_frame_des #(.DATA_W(32), .PARITY_EN(1)) u_dut_b (
        .clk (clk), .rst (rst), .en (1'b1), .ser_in (ser_b), .clr_cnt (1'b0),
        .data_out (data_b), .valid_out (valid_b), .armed (armed_b),
        .frame_cnt (fcnt_b), .err_frame_cnt (ferr_b), .err_par_cnt (perr_b), .err_to_cnt (to_b)
    );

    icm_frame_des #(.CNT_W(2)) u_dut_c (
        .clk (clk), .rst (rst), .en (en_c), .ser_in (ser_c), .clr_cnt (clr_c),
        .data_out (data_c), .valid_out (valid_c), .armed (armed_c),
        .frame_cnt (fcnt_c), .err_frame_cnt (ferr_c), .err_par_cnt (perr_c), .err_to_cnt (to_c)
    );

    int pulses_a, pulses_b, pulses_c;
    int n_cmp = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            pulses_a <= 0;
            pulses_b <= 0;
            pulses_c <= 0;
        end else begin
            if (valid_a) pulses_a <= pulses_a + 1;
            if (valid_b) pulses_b <= pulses_b + 1;
            if (valid_c) pulses_c <= pulses_c + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        ser_bit = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        ser_bit = v;
        repeat (SC) @(negedge clk);
    endtask

    // Preamble, marker, lead framing bit, payload MSB first, optional parity, trail framing bit.
    task automatic send_frame(input int dw, input logic [63:0] pay, input bit par_en,
                              input bit par_flip, input bit lead, input int pre);
        logic par;
        par = (^pay) ^ par_flip;
        ser_bit = 1'b0;
        repeat (pre) @(negedge clk);
        drive_bit(1'b1);
        drive_bit(lead);
        for (int i = dw - 1; i >= 0; i--) drive_bit(pay[i]);
        if (par_en) drive_bit(par);
        drive_bit(1'b0);
        ser_bit = 1'b1;
    endtask

    initial begin
        int base;
        rst = 1'b1; en_c = 1'b1; clr_a = 1'b0; clr_c = 1'b0; ser_bit = 1'b1; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_armed", armed_a, 0);
        check("rst_fcnt", fcnt_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_to", to_a, 0);
        rst = 1'b0;

        // Plain 48-bit frame, exact valid latency
        idle(2010);
        check("a_armed", armed_a, 1);
        base = pulses_a;
        send_frame(48, 64'h1234_5678_9ABC, 0, 0, 0, 10);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("a_valid_early", valid_a, 0);
        @(negedge clk);
        check("a_valid", valid_a, 1);
        check("a_data", data_a, 48'h1234_5678_9ABC);
        idle(20);
        check("a_pulses", pulses_a - base, 1);
        check("a_fcnt", fcnt_a, 1);

        // Leading framing bit high
        base = pulses_a;
        send_frame(48, 64'hCAFE, 0, 0, 1, 10);
        idle(30);
        check("a_ferr_pulses", pulses_a - base, 0);
        check("a_ferr_data", data_a, 48'h1234_5678_9ABC);
        check("a_ferr", ferr_a, 1);
        check("a_ferr_fcnt", fcnt_a, 1);

        clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
        check("a_clr_fcnt", fcnt_a, 0);
        check("a_clr_ferr", ferr_a, 0);

        // Back-to-back frames, no idle wait in between
        base = pulses_a;
        send_frame(48, 64'h1, 0, 0, 0, 10);
        idle(5);
        send_frame(48, 64'h2, 0, 0, 0, 10);
        idle(30);
        check("a_b2b_pulses", pulses_a - base, 2);
        check("a_b2b_fcnt", fcnt_a, 2);
        check("a_b2b_data", data_a, 48'h2);

        // Preamble timeout, then a frame without the idle qualification
        ser_bit = 1'b0;
        repeat (110) @(negedge clk);
        check("a_to_armed", armed_a, 0);
        check("a_to_cnt", to_a, 1);
        idle(50);
        base = pulses_a;
        send_frame(48, 64'h55, 0, 0, 0, 10);
        idle(30);
        check("a_ign_pulses", pulses_a - base, 0);
        check("a_ign_fcnt", fcnt_a, 2);
        check("a_ign_data", data_a, 48'h2);
        check("a_ign_to", to_a, 1);
        check("a_ign_armed", armed_a, 0);

        // Parity configuration: 0xFFFF0001 has 17 ones, so the even-parity bit is 1
        sel = 1;
        idle(2010);
        check("b_armed", armed_b, 1);
        base = pulses_b;
        send_frame(32, 64'hFFFF_0001, 1, 1, 0, 10);
        idle(30);
        check("b_bad_pulses", pulses_b - base, 0);
        check("b_perr", perr_b, 1);
        check("b_bad_data", data_b, 0);
        base = pulses_b;
        send_frame(32, 64'hFFFF_0001, 1, 0, 0, 10);
        idle(30);
        check("b_good_pulses", pulses_b - base, 1);
        check("b_good_data", data_b, 32'hFFFF_0001);
        check("b_good_fcnt", fcnt_b, 1);
        check("b_good_perr", perr_b, 1);
        send_frame(32, 64'h7, 1, 1, 1, 10);
        idle(30);
        check("b_prio_ferr", ferr_b, 1);
        check("b_prio_perr", perr_b, 1);

        // 2-bit counters: saturation, clear colliding with an increment, enable drop
        sel = 2;
        idle(10);
        for (int k = 0; k < 5; k++) begin
            send_frame(48, 64'h3C, 0, 0, 1, 10);
            idle(5);
        end
        idle(20);
        check("c_sat", ferr_c, 3);
        send_frame(48, 64'h3C, 0, 0, 1, 10);
        @(posedge clk); @(posedge clk); @(negedge clk);
        clr_c = 1'b1;
        @(negedge clk);
        clr_c = 1'b0;
        check("c_clr_inc", ferr_c, 0);
        idle(20);
        check("c_clr_hold", ferr_c, 0);

        base = pulses_c;
        send_frame(48, 64'hABC, 0, 0, 0, 10);
        idle(30);
        check("c_good_pulses", pulses_c - base, 1);
        check("c_good_data", data_c, 48'hABC);
        check("c_good_fcnt", fcnt_c, 1);

        base = pulses_c;
        fork
            send_frame(48, 64'hDEF, 0, 0, 0, 10);
            begin
                repeat (500) @(negedge clk);
                en_c = 1'b0;
                repeat (3) @(negedge clk);
                check("c_en_armed", armed_c, 0);
                check("c_en_data", data_c, 0);
                check("c_en_valid", valid_c, 0);
                en_c = 1'b1;
            end
        join
        idle(30);
        check("c_drop_pulses", pulses_c - base, 0);
        check("c_drop_fcnt", fcnt_c, 1);
        check("c_drop_ferr", ferr_c, 0);
        check("c_drop_perr", perr_c, 0);
        check("c_drop_to", to_c, 0);
        check("c_drop_data", data_c, 0);
        check("c_drop_armed", armed_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
